// File: rtl/m6809_pkg.sv
// Shared definitions for the 6809 front-end: sequencer states, bus owner codes
// and the opcodes the sequencer treats specially.
package m6809_pkg;

  typedef enum logic [2:0] {
    ST_RST_HI,
    ST_RST_LO,
    ST_FETCH_OP,
    ST_FETCH_PB,
    ST_MOVE,
    ST_EXEC
  } state_t;

  localparam logic [1:0] SEL_SEQ   = 2'd0;
  localparam logic [1:0] SEL_MOVER = 2'd1;
  localparam logic [1:0] SEL_EXEC  = 2'd2;

  localparam logic [7:0] OP_PSHS = 8'h34;
  localparam logic [7:0] OP_PULS = 8'h35;
  localparam logic [7:0] OP_PSHU = 8'h36;
  localparam logic [7:0] OP_PULU = 8'h37;
  localparam logic [7:0] OP_NOP  = 8'h12;

  localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFE;

  // PSH/PUL opcodes are the only ones followed by a register-list post-byte.
  function automatic logic is_stack_op(input logic [7:0] op);
    return (op >= OP_PSHS) && (op <= OP_PULU);
  endfunction

endpackage

// File: rtl/m6809_pb_bytecount.sv
// PSH/PUL post-byte to transferred byte count: bits 7..4 select 16-bit
// registers (2 bytes each), bits 3..0 select 8-bit registers.
module m6809_pb_bytecount (
  input  logic [7:0] pb,
  output logic [3:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++)
      cnt = cnt + {2'b00, pb[i] && (i >= 4), pb[i] && (i < 4)};
  end

endmodule

// File: rtl/m6809_core_fetch_seq.sv
// 6809 front-end sequencer: reset vector fetch, opcode/post-byte fetch, and
// hand-off of the bus to the register mover or the execute unit.
module m6809_core_fetch_seq
  import m6809_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [7:0]  din,
  input  logic [15:0] pc_in,
  output logic [15:0] addr,
  output logic [1:0]  bus_sel,
  output logic [7:0]  ir_q,
  output logic        start,
  output logic [15:0] pc_out,
  output logic        pc_out_en,
  output logic        exec_req,
  input  logic        exec_done,
  output logic        move_busy
);

  state_t      state, nxt;
  logic [3:0]  move_cnt;
  logic [3:0]  pb_cnt;
  logic [7:0]  vec_hi;
  logic [15:0] pc_inc;

  m6809_pb_bytecount u_bytecount (
    .pb  (din),
    .cnt (pb_cnt)
  );

  assign pc_inc = pc_in + 16'd1;

  always_ff @(posedge clk) begin
    if (!reset_b) state <= ST_RST_HI;
    else          state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      ir_q     <= OP_NOP;
      move_cnt <= '0;
      vec_hi   <= '0;
    end else begin
      case (state)
        ST_RST_HI:   vec_hi   <= din;
        ST_FETCH_OP: ir_q     <= din;
        ST_FETCH_PB: move_cnt <= pb_cnt;
        ST_MOVE:     move_cnt <= move_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_RST_HI:   nxt = ST_RST_LO;
      ST_RST_LO:   nxt = ST_FETCH_OP;
      ST_FETCH_OP: nxt = is_stack_op(din) ? ST_FETCH_PB : ST_EXEC;
      ST_FETCH_PB: nxt = (pb_cnt == 4'd0) ? ST_FETCH_OP : ST_MOVE;
      ST_MOVE:     nxt = (move_cnt == 4'd1) ? ST_FETCH_OP : ST_MOVE;
      ST_EXEC:     nxt = exec_done ? ST_FETCH_OP : ST_EXEC;
      default:     nxt = ST_RST_HI;
    endcase
  end

  // The mover owns PC writes while it runs, so the sequencer stays off pc_out_en.
  always_comb begin
    addr      = 16'h0000;
    pc_out    = 16'h0000;
    pc_out_en = 1'b0;
    start     = 1'b0;
    exec_req  = 1'b0;
    move_busy = 1'b0;
    bus_sel   = SEL_SEQ;
    case (state)
      ST_RST_HI: addr = RESET_VECTOR;
      ST_RST_LO: begin
        addr      = RESET_VECTOR + 16'd1;
        pc_out    = {vec_hi, din};
        pc_out_en = 1'b1;
      end
      ST_FETCH_OP: begin
        addr      = pc_in;
        pc_out    = pc_inc;
        pc_out_en = 1'b1;
      end
      ST_FETCH_PB: begin
        addr      = pc_in;
        start     = 1'b1;
        pc_out    = pc_inc;
        pc_out_en = 1'b1;
      end
      ST_MOVE: begin
        bus_sel   = SEL_MOVER;
        move_busy = 1'b1;
      end
      ST_EXEC: begin
        bus_sel  = SEL_EXEC;
        exec_req = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_m6809_core_fetch_seq.sv
// Scoreboard bench: an instruction-level model expands each instruction into
// expected bus cycles; a negedge monitor compares them against the DUT.
module tb_m6809_core_fetch_seq;
  import m6809_pkg::*;

  localparam logic [15:0] RV  = 16'hFFFE;
  localparam logic [15:0] RV1 = 16'hFFFF;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  sel;
    logic        start;
    logic [15:0] pc_out;
    logic        pc_en;
    logic        exec_req;
    logic        busy;
    logic [7:0]  ir;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_b, exec_done;
  logic [7:0]  din, ir_q;
  logic [15:0] pc_in, addr, pc_out;
  logic [1:0]  bus_sel;
  logic        start, pc_out_en, exec_req, move_busy;
  logic        pull_en;
  logic [15:0] pull_val;
  logic [7:0]  mem [0:65535];

  always #5 clk = ~clk;

  m6809_core_fetch_seq #(.RESET_VECTOR(RV)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .din       (din),
    .pc_in     (pc_in),
    .addr      (addr),
    .bus_sel   (bus_sel),
    .ir_q      (ir_q),
    .start     (start),
    .pc_out    (pc_out),
    .pc_out_en (pc_out_en),
    .exec_req  (exec_req),
    .exec_done (exec_done),
    .move_busy (move_busy)
  );

  // Environment: memory and the register file's PC (mover pulls win).
  assign din = mem[addr];
  always @(posedge clk) begin
    if (pull_en)        pc_in <= pull_val;
    else if (pc_out_en) pc_in <= pc_out;
  end

  obs_t exp_q [$];
  bit   chk_q [$];
  int   checks = 0, errors = 0, cyc_no = 0;
  obs_t e, got;
  bit   c;

  always @(negedge clk) begin
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = chk_q.pop_front();
      got = '{addr, bus_sel, start, pc_out, pc_out_en, exec_req, move_busy, ir_q};
      if (c) begin
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL cycle%0d: got addr=%h sel=%0d start=%b pc_out=%h en=%b req=%b busy=%b ir=%h; expected addr=%h sel=%0d start=%b pc_out=%h en=%b req=%b busy=%b ir=%h",
                   cyc_no, got.addr, got.sel, got.start, got.pc_out, got.pc_en, got.exec_req, got.busy, got.ir,
                   e.addr, e.sel, e.start, e.pc_out, e.pc_en, e.exec_req, e.busy, e.ir);
        end
      end
    end
  end

  // Reference model state
  logic [15:0] m_pc;
  logic [7:0]  m_ir;

  function automatic obs_t mk(input logic [15:0] a, input logic [1:0] s, input logic st,
                              input logic [15:0] po, input logic en, input logic rq, input logic bz);
    return '{a, s, st, po, en, rq, bz, m_ir};
  endfunction

  function automatic logic stray();
    return ($urandom_range(3) == 0);
  endfunction

  task automatic cyc(input obs_t ex, input bit chk, input logic rb, input logic done,
                     input logic pe, input logic [15:0] pv);
    reset_b = rb; exec_done = done; pull_en = pe; pull_val = pv;
    exp_q.push_back(ex);
    chk_q.push_back(chk);
    @(posedge clk); #1;
  endtask

  task automatic vec_fetch();
    logic [7:0] hi, lo;
    hi = mem[RV]; lo = mem[RV1];
    cyc(mk(RV, SEL_SEQ, 0, 16'h0, 0, 0, 0), 1, 1, stray(), 0, 0);
    cyc(mk(RV1, SEL_SEQ, 0, {hi, lo}, 1, 0, 0), 1, 1, stray(), 0, 0);
    m_pc = {hi, lo};
  endtask

  task automatic do_reset(input int n);
    repeat (n) cyc('0, 0, 0, 0, 0, 0);
    m_ir = OP_NOP;
    vec_fetch();
  endtask

  // One instruction; abort_at>=0 pulls reset low on that mover cycle.
  task automatic instr(input int wait_n, input int pull_at, input logic [15:0] pv, input int abort_at);
    logic [7:0] op, pb;
    int n;
    op = mem[m_pc];
    cyc(mk(m_pc, SEL_SEQ, 0, m_pc + 16'd1, 1, 0, 0), 1, 1, stray(), 0, 0);
    m_ir = op;
    m_pc = m_pc + 16'd1;
    if (op >= 8'h34 && op <= 8'h37) begin
      pb = mem[m_pc];
      n = 2 * $countones(pb[7:4]) + $countones(pb[3:0]);
      cyc(mk(m_pc, SEL_SEQ, 1, m_pc + 16'd1, 1, 0, 0), 1, 1, stray(), 0, 0);
      m_pc = m_pc + 16'd1;
      for (int i = 0; i < n; i++) begin
        if (i == abort_at) begin
          cyc(mk(16'h0, SEL_MOVER, 0, 16'h0, 0, 0, 1), 1, 0, stray(), 0, 0);
          m_ir = OP_NOP;
          vec_fetch();
          return;
        end
        cyc(mk(16'h0, SEL_MOVER, 0, 16'h0, 0, 0, 1), 1, 1, stray(), i == pull_at, pv);
        if (i == pull_at) m_pc = pv;
      end
    end else begin
      repeat (wait_n) cyc(mk(16'h0, SEL_EXEC, 0, 16'h0, 0, 1, 0), 1, 1, 0, 0, 0);
      cyc(mk(16'h0, SEL_EXEC, 0, 16'h0, 0, 1, 0), 1, 1, 1, 0, 0);
    end
  endtask

  initial begin
    reset_b = 0; exec_done = 0; pull_en = 0; pull_val = 0;
    for (int i = 0; i < 65536; i++) mem[i] = OP_NOP;
    @(posedge clk); #1;

    // Reset vector 1234, NOP executes
    mem[RV] = 8'h12; mem[RV1] = 8'h34;
    do_reset(2);
    instr(3, -1, 0, -1);

    // PSHS all registers: 12 mover cycles, next fetch at 1002
    mem[RV] = 8'h10; mem[RV1] = 8'h00;
    mem[16'h1000] = 8'h34; mem[16'h1001] = 8'hFF; mem[16'h1002] = 8'h12;
    do_reset(2);
    instr(0, -1, 0, -1);
    instr(1, -1, 0, -1);

    // PULU with empty register list
    mem[16'h1000] = 8'h37; mem[16'h1001] = 8'h00;
    do_reset(1);
    instr(0, -1, 0, -1);
    instr(0, -1, 0, -1);

    // PULS PC pulled on the last mover cycle
    mem[16'h1000] = 8'h35; mem[16'h1001] = 8'h80; mem[16'h4000] = 8'h12;
    do_reset(1);
    instr(0, 1, 16'h4000, -1);
    instr(0, -1, 0, -1);

    // Execute handshake with a long wait
    mem[16'h1000] = 8'h86;
    do_reset(1);
    instr(5, -1, 0, -1);
    instr(2, -1, 0, -1);

    // Reset on 3rd mover cycle, then vector FFFF -> PC wrap
    mem[16'h1000] = 8'h34; mem[16'h1001] = 8'hFF;
    do_reset(1);
    mem[RV] = 8'hFF; mem[RV1] = 8'hFF;
    instr(0, -1, 0, 2);
    instr(2, -1, 0, -1);
    instr(0, -1, 0, -1);

    // Randomized programs
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(4) == 0) ? 8'h34 + 8'($urandom_range(3)) : 8'($urandom);
    do_reset(1 + $urandom_range(1));
    for (int k = 0; k < 300; k++) begin
      instr($urandom_range(4),
            ($urandom_range(2) == 0) ? int'($urandom_range(11)) : -1,
            16'($urandom),
            ($urandom_range(39) == 0) ? int'($urandom_range(3)) : -1);
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
